// File: rtl/tpu_vector_loader_if.sv
// rtl/tpu_vector_loader_if.sv - operand input and packed vector output bundle of the vector loader
interface tpu_vector_loader_if #(
   parameter int N_LANES = 128,
   parameter int WORD_W  = 16
);
   localparam int CNT_W = $clog2(N_LANES);

   logic                      in_valid;
   logic                      in_ready;
   logic [WORD_W-1:0]         in_data1;
   logic [WORD_W-1:0]         in_data2;
   logic [N_LANES*WORD_W-1:0] vec_data1;
   logic [N_LANES*WORD_W-1:0] vec_data2;
   logic                      vec_valid;
   logic                      vec_ack;
   logic [CNT_W-1:0]          word_cnt;

   // Producer/consumer side: feeds operand pairs and acknowledges settled vectors.
   modport master (
      output in_valid, in_data1, in_data2, vec_ack,
      input  in_ready, vec_data1, vec_data2, vec_valid, word_cnt
   );

   // Loader side.
   modport slave (
      input  in_valid, in_data1, in_data2, vec_ack,
      output in_ready, vec_data1, vec_data2, vec_valid, word_cnt
   );
endinterface

// File: rtl/tpu_vector_loader.sv
// rtl/tpu_vector_loader.sv - packs operand pairs into two lane vectors and holds them settled for the MAC tree
module tpu_vector_loader #(
   parameter int N_LANES       = 128,
   parameter int WORD_W        = 16,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   tpu_vector_loader_if.slave bus
);
   localparam int CNT_W = $clog2(N_LANES);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [1:0] ST_FILL   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   localparam logic [CNT_W-1:0] LAST_LANE   = CNT_W'(N_LANES - 1);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

   logic [1:0]                state;
   logic [CNT_W-1:0]          word_cnt;
   logic [SET_W-1:0]          settle_cnt;
   logic [N_LANES*WORD_W-1:0] vec1;
   logic [N_LANES*WORD_W-1:0] vec2;
   logic                      beat;

   // Ready and valid depend on state only, so there is no in_valid -> in_ready path.
   assign bus.in_ready  = (state == ST_FILL);
   assign bus.vec_valid = (state == ST_HOLD);
   assign bus.word_cnt  = word_cnt;
   assign bus.vec_data1 = vec1;
   assign bus.vec_data2 = vec2;
   assign beat          = bus.in_valid & (state == ST_FILL);

   // Sequencing: fill lanes, let the MAC tree settle, then hold until the consumer acks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_FILL;
         word_cnt   <= '0;
         settle_cnt <= '0;
      end else if (clr) begin
         state      <= ST_FILL;
         word_cnt   <= '0;
         settle_cnt <= '0;
      end else begin
         case (state)
            ST_FILL: begin
               if (beat) begin
                  if (word_cnt == LAST_LANE) begin
                     word_cnt   <= '0;
                     settle_cnt <= '0;
                     state      <= ST_SETTLE;
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               settle_cnt <= settle_cnt + 1'b1;
               if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (bus.vec_ack) begin
                  state <= ST_FILL;
               end
            end
            default: begin
               state      <= ST_FILL;
               word_cnt   <= '0;
               settle_cnt <= '0;
            end
         endcase
      end
   end

   // Lane write: only the addressed lane changes; contents survive clr and are simply overwritten next fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec1 <= '0;
         vec2 <= '0;
      end else if (beat && !clr) begin
         vec1[int'(word_cnt)*WORD_W +: WORD_W] <= bus.in_data1;
         vec2[int'(word_cnt)*WORD_W +: WORD_W] <= bus.in_data2;
      end
   end
endmodule

// File: tb/tb_tpu_vector_loader.sv
// tb/tb_tpu_vector_loader.sv - randomized self-checking bench for tpu_vector_loader against a lane-array model
module tb_tpu_vector_loader;
   localparam int N_LANES       = 128;
   localparam int WORD_W        = 16;
   localparam int SETTLE_CYCLES = 4;

   logic clk;
   logic rst;
   logic clr;

   tpu_vector_loader_if #(.N_LANES(N_LANES), .WORD_W(WORD_W)) bus ();

   tpu_vector_loader #(
      .N_LANES       (N_LANES),
      .WORD_W        (WORD_W),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) dut (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_pass;
   logic [WORD_W-1:0] exp1 [N_LANES];
   logic [WORD_W-1:0] exp2 [N_LANES];
   int mw;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] gen(input int pat, input int i);
      logic [15:0] a;
      logic [15:0] b;
      case (pat)
         0: begin a = 16'(i);  b = 16'h0100 + 16'(i); end
         1: begin a = ~16'(i); b = 16'($urandom);      end
         2: begin a = 16'h0001; b = 16'h0001;          end
         default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      return {a, b};
   endfunction

   function automatic logic [63:0] mac_ref();
      logic [63:0] s = 0;
      for (int i = 0; i < N_LANES; i++) s += 64'(exp1[i]) * 64'(exp2[i]);
      return s;
   endfunction

   function automatic logic [63:0] mac_dut();
      logic [63:0] s = 0;
      for (int i = 0; i < N_LANES; i++)
         s += 64'(bus.vec_data1[i*WORD_W +: WORD_W]) * 64'(bus.vec_data2[i*WORD_W +: WORD_W]);
      return s;
   endfunction

   task automatic check_lanes(input string tag);
      for (int i = 0; i < N_LANES; i++) begin
         check({tag, "_d1"}, 64'(bus.vec_data1[i*WORD_W +: WORD_W]), 64'(exp1[i]));
         check({tag, "_d2"}, 64'(bus.vec_data2[i*WORD_W +: WORD_W]), 64'(exp2[i]));
      end
   endtask

   // Stream cnt accepted beats with in_valid asserted pct percent of cycles.
   task automatic load_beats(input int pat, input int pct, input int cnt);
      int done = 0;
      int guard = 0;
      logic [31:0] d;
      while (done < cnt && guard < 4000) begin
         bus.in_valid = ($urandom_range(99) < pct);
         d = gen(pat, mw);
         bus.in_data1 = d[31:16];
         bus.in_data2 = d[15:0];
         check("fill_ready", 64'(bus.in_ready), 64'd1);
         check("fill_word_cnt", 64'(bus.word_cnt), 64'(mw));
         check("fill_vec_valid", 64'(bus.vec_valid), 64'd0);
         if (bus.in_valid) begin
            exp1[mw] = d[31:16];
            exp2[mw] = d[15:0];
            mw = (mw + 1) % N_LANES;
            done++;
         end
         tick();
         guard++;
      end
      if (done < cnt) check("load_timeout", 64'(done), 64'(cnt));
      bus.in_valid = 1'b0;
   endtask

   // Called right after the 128th beat: settle timing, hold stability, ack release.
   task automatic finish_vec(input int hold);
      bus.in_valid = 1'b1;
      bus.in_data1 = 16'($urandom);
      bus.in_data2 = 16'($urandom);
      bus.vec_ack  = 1'b1;
      check("settle_ready", 64'(bus.in_ready), 64'd0);
      check("settle_valid0", 64'(bus.vec_valid), 64'd0);
      check("settle_word_cnt", 64'(bus.word_cnt), 64'd0);
      for (int k = 1; k < SETTLE_CYCLES; k++) begin
         tick();
         bus.in_data1 = 16'($urandom);
         bus.in_data2 = 16'($urandom);
         check("settle_valid", 64'(bus.vec_valid), 64'd0);
         check("settle_ready_k", 64'(bus.in_ready), 64'd0);
      end
      tick();
      bus.vec_ack = 1'b0;
      check("valid_rise", 64'(bus.vec_valid), 64'd1);
      check_lanes("load");
      check("mac_sum", mac_dut(), mac_ref());
      for (int k = 0; k < hold; k++) begin
         bus.in_data1 = 16'($urandom);
         bus.in_data2 = 16'($urandom);
         tick();
         check("hold_valid", 64'(bus.vec_valid), 64'd1);
         check("hold_ready", 64'(bus.in_ready), 64'd0);
      end
      check_lanes("hold");
      bus.in_valid = 1'b0;
      bus.vec_ack  = 1'b1;
      tick();
      bus.vec_ack  = 1'b0;
      check("ack_valid", 64'(bus.vec_valid), 64'd0);
      check("ack_ready", 64'(bus.in_ready), 64'd1);
      check("ack_word_cnt", 64'(bus.word_cnt), 64'd0);
      mw = 0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      mw       = 0;
      for (int i = 0; i < N_LANES; i++) begin
         exp1[i] = '0;
         exp2[i] = '0;
      end
      rst = 1'b1;
      clr = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data1 = '0;
      bus.in_data2 = '0;
      bus.vec_ack  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("rst_ready", 64'(bus.in_ready), 64'd1);
      check("rst_valid", 64'(bus.vec_valid), 64'd0);
      check("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
      check("rst_vec1_zero", 64'(bus.vec_data1 == '0), 64'd1);
      check("rst_vec2_zero", 64'(bus.vec_data2 == '0), 64'd1);

      // Asynchronous reset in the middle of a fill
      load_beats(3, 100, 50);
      check("pre_rst_word_cnt", 64'(bus.word_cnt), 64'd50);
      #2 rst = 1'b1;
      #1;
      check("midrst_word_cnt", 64'(bus.word_cnt), 64'd0);
      check("midrst_valid", 64'(bus.vec_valid), 64'd0);
      check("midrst_ready", 64'(bus.in_ready), 64'd1);
      check("midrst_vec1_zero", 64'(bus.vec_data1 == '0), 64'd1);
      check("midrst_vec2_zero", 64'(bus.vec_data2 == '0), 64'd1);
      tick();
      rst = 1'b0;
      tick();
      mw = 0;
      for (int i = 0; i < N_LANES; i++) begin
         exp1[i] = '0;
         exp2[i] = '0;
      end

      // Full back-to-back load with the counting pattern, held 20 cycles before ack
      load_beats(0, 100, N_LANES);
      finish_vec(20);
      check("lane127_d1", 64'(bus.vec_data1[127*WORD_W +: WORD_W]), 64'h007F);
      check("lane127_d2", 64'(bus.vec_data2[127*WORD_W +: WORD_W]), 64'h017F);

      // Backpressure: random gaps on in_valid
      load_beats(3, 50, N_LANES);
      finish_vec($urandom_range(1, 8));

      // Abort at lane 64 with a concurrent beat
      load_beats(3, 100, 64);
      bus.in_valid = 1'b1;
      bus.in_data1 = 16'($urandom);
      bus.in_data2 = 16'($urandom);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      bus.in_valid = 1'b0;
      check("clr_word_cnt", 64'(bus.word_cnt), 64'd0);
      check("clr_ready", 64'(bus.in_ready), 64'd1);
      check("clr_valid", 64'(bus.vec_valid), 64'd0);
      check("clr_lane64_kept", 64'(bus.vec_data1[64*WORD_W +: WORD_W]), 64'(exp1[64]));
      check("clr_lane0_kept", 64'(bus.vec_data2[0 +: WORD_W]), 64'(exp2[0]));
      mw = 0;
      load_beats(0, 70, N_LANES);
      finish_vec(3);

      // Back-to-back vectors, then the all-ones MAC case
      load_beats(3, 100, N_LANES);
      finish_vec(1);
      load_beats(1, 100, N_LANES);
      finish_vec(2);
      load_beats(2, 100, N_LANES);
      finish_vec(0);
      check("mac_ones", mac_dut(), 64'd128);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
